// File: rtl/systolic_seq_ctrl.sv
// Pass sequencer for the NxN systolic array: stream B/A operands into the array,
// run the shift phase, then drain the column partial sums onto an output stream.
module systolic_seq_ctrl #(
    parameter int N              = 8,
    parameter int DW             = 16,
    parameter int COMPUTE_CYCLES = 16,
    localparam int BW            = $clog2(N * N),
    localparam int AW            = $clog2(N),
    localparam int CW            = $clog2(COMPUTE_CYCLES + 1)
) (
    input  logic          Clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic          skip_b,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          external_we,
    output logic          sel_a_or_b,
    output logic [BW-1:0] b_sel,
    output logic [AW-1:0] a_sel,
    output logic [DW-1:0] external_wdata,
    output logic          b_we_array_flat_sig,
    output logic          data_clear,
    output logic          en_shift_right,
    output logic          en_shift_bottom,
    output logic [AW-1:0] ps_sel,
    input  logic [DW-1:0] ps_bottom_out,
    output logic [2:0]    dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_LOAD_B  = 3'd2;
    localparam logic [2:0] S_LOAD_A  = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [BW-1:0] B_LAST = BW'(N * N - 1);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COMPUTE_CYCLES - 1);

    // Handshakes: a beat transfers on a rising Clock edge where valid and ready are
    // both high; in_ready/out_valid depend only on state, never on the partner's signal.

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          skip_r;
    logic [BW-1:0] b_cnt;
    logic [AW-1:0] a_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [AW-1:0] col_cnt;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = skip_r ? S_LOAD_A : S_LOAD_B;
            S_LOAD_B:  if (in_fire && b_cnt == B_LAST) state_nxt = S_LOAD_A;
            S_LOAD_A:  if (in_fire && a_cnt == A_LAST) state_nxt = S_COMPUTE;
            S_COMPUTE: if (cyc_cnt == C_LAST) state_nxt = S_DRAIN;
            S_DRAIN:   if (out_fire && col_cnt == A_LAST) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            skip_r  <= 1'b0;
            b_cnt   <= '0;
            a_cnt   <= '0;
            cyc_cnt <= '0;
            col_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                b_cnt   <= '0;
                a_cnt   <= '0;
                cyc_cnt <= '0;
                col_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE:    if (start) skip_r <= skip_b;
                    S_LOAD_B:  if (in_fire) b_cnt <= (b_cnt == B_LAST) ? '0 : b_cnt + 1'b1;
                    S_LOAD_A:  if (in_fire) a_cnt <= (a_cnt == A_LAST) ? '0 : a_cnt + 1'b1;
                    S_COMPUTE: cyc_cnt <= (cyc_cnt == C_LAST) ? '0 : cyc_cnt + 1'b1;
                    S_DRAIN:   if (out_fire) col_cnt <= (col_cnt == A_LAST) ? '0 : col_cnt + 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    // Write data and drained sums are gated so idle outputs read as zero.
    always_comb begin
        busy                = (state != S_IDLE);
        done                = (state == S_DONE);
        in_ready            = (state == S_LOAD_B) || (state == S_LOAD_A);
        external_we         = in_valid & in_ready;
        external_wdata      = in_ready ? in_data : '0;
        sel_a_or_b          = (state == S_LOAD_A);
        b_sel               = b_cnt;
        a_sel               = a_cnt;
        b_we_array_flat_sig = (state == S_LOAD_B);
        data_clear          = (state == S_CLEAR);
        en_shift_right      = (state == S_COMPUTE);
        en_shift_bottom     = (state == S_COMPUTE);
        out_valid           = (state == S_DRAIN);
        out_data            = out_valid ? ps_bottom_out : '0;
        ps_sel              = col_cnt;
        dbg_state           = state;
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: random operands, a matrix-vector reference
// model for the drained column sums, and expected write/output queues.
module tb_systolic_seq_ctrl;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CC = 16;
    localparam int WW = 1 + 6 + DW + 1;
    localparam int OW = 3 + DW;

    logic          Clock;
    logic          rst_n;
    logic          start;
    logic          skip_b;
    logic          abort;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          external_we;
    logic          sel_a_or_b;
    logic [5:0]    b_sel;
    logic [2:0]    a_sel;
    logic [DW-1:0] external_wdata;
    logic          b_we_array_flat_sig;
    logic          data_clear;
    logic          en_shift_right;
    logic          en_shift_bottom;
    logic [2:0]    ps_sel;
    logic [DW-1:0] ps_bottom_out;
    logic [2:0]    dbg_state;

    systolic_seq_ctrl #(.N(N), .DW(DW), .COMPUTE_CYCLES(CC)) dut (
        .Clock(Clock), .rst_n(rst_n), .start(start), .skip_b(skip_b), .abort(abort),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .external_we(external_we), .sel_a_or_b(sel_a_or_b),
        .b_sel(b_sel), .a_sel(a_sel), .external_wdata(external_wdata),
        .b_we_array_flat_sig(b_we_array_flat_sig), .data_clear(data_clear),
        .en_shift_right(en_shift_right), .en_shift_bottom(en_shift_bottom),
        .ps_sel(ps_sel), .ps_bottom_out(ps_bottom_out), .dbg_state(dbg_state)
    );

    logic [WW-1:0] wr_exp_q[$];
    logic [OW-1:0] out_exp_q[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] b_mem[N*N];
    logic [DW-1:0] a_mem[N];
    logic [DW-1:0] col_sum[N];
    int n_cmp = 0;
    int n_fail = 0;
    int shift_cnt = 0;
    int clear_cnt = 0;
    int done_cnt = 0;
    int out_beats = 0;
    int valid_pct = 100;
    int stall_left = 0;
    logic [WW-1:0] act_w;
    logic [WW-1:0] exp_w;
    logic [OW-1:0] exp_o;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, in_ready, out_valid, external_we, sel_a_or_b, b_sel, a_sel,
                external_wdata, b_we_array_flat_sig, data_clear, en_shift_right,
                en_shift_bottom, ps_sel, out_data, dbg_state};
    endfunction

    // clock / array model
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always_comb ps_bottom_out = col_sum[ps_sel];

    // input stream source
    initial begin
        bit acc;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge Clock);
            acc = in_valid && in_ready;
            @(posedge Clock);
            #1;
            if (acc && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
        end
    end

    // output sink, with an optional stall once column 3 is presented
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            if (stall_left > 0 && (!out_ready || (out_valid && ps_sel == 3'd3))) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge Clock) begin
        if (rst_n) begin
            check("we_handshake", external_we, in_valid & in_ready);
            if (external_we) begin
                act_w = {sel_a_or_b, sel_a_or_b ? {3'b000, a_sel} : b_sel,
                         external_wdata, b_we_array_flat_sig};
                if (wr_exp_q.size() == 0) begin
                    check("write_unexpected", act_w, '0);
                end else begin
                    exp_w = wr_exp_q.pop_front();
                    check("write", act_w, exp_w);
                end
            end
            if (out_valid && out_ready) begin
                out_beats++;
                if (out_exp_q.size() == 0) begin
                    check("out_unexpected", {ps_sel, out_data}, '0);
                end else begin
                    exp_o = out_exp_q.pop_front();
                    check("out_beat", {ps_sel, out_data}, exp_o);
                end
            end
            if (!out_ready) check("stall_hold", {out_valid, ps_sel}, {1'b1, 3'd3});
            if (en_shift_right || en_shift_bottom)
                check("shift_pair", en_shift_bottom, en_shift_right);
            shift_cnt += int'(en_shift_right);
            clear_cnt += int'(data_clear);
            done_cnt  += int'(done);
        end
    end

    task automatic wait_state(input logic [2:0] st, inout int cyc);
        while (dbg_state != st && cyc < 1000) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        check("reach_state", dbg_state, st);
    endtask

    task automatic run_pass(input bit skip, input bit directed, input bit do_abort,
                            input bit do_rst, input bit chk_lat);
        int cyc;
        int shift0;
        int clear0;
        int done0;
        int beats0;
        bit got;
        logic [DW-1:0] acc;
        for (int j = 0; j < N; j++) a_mem[j] = directed ? DW'(16'h100 + j) : DW'($urandom);
        if (!skip) begin
            for (int i = 0; i < N * N; i++) begin
                b_mem[i] = directed ? DW'(i) : DW'($urandom);
                wr_exp_q.push_back({1'b0, 6'(i), b_mem[i], 1'b1});
                src_q.push_back(b_mem[i]);
            end
        end
        for (int j = 0; j < N; j++) begin
            wr_exp_q.push_back({1'b1, 6'(j), a_mem[j], 1'b0});
            src_q.push_back(a_mem[j]);
        end
        for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int r = 0; r < N; r++) acc = acc + a_mem[r] * b_mem[r*N + c];
            col_sum[c] = acc;
            out_exp_q.push_back({3'(c), acc});
        end
        shift0 = shift_cnt;
        clear0 = clear_cnt;
        done0  = done_cnt;
        beats0 = out_beats;
        @(posedge Clock);
        #1;
        skip_b = skip;
        start  = 1'b1;
        @(posedge Clock);
        #1;
        start  = 1'b0;
        skip_b = 1'($urandom);
        cyc    = 1;
        if (do_abort) begin
            wait_state(3'd4, cyc);
            repeat (5) @(posedge Clock);
            #1;
            check("abort_shifts_before", shift_cnt - shift0, 5);
            abort = 1'b1;
            @(posedge Clock);
            #1;
            abort = 1'b0;
            @(negedge Clock);
            check("abort_idle", {busy, done, en_shift_right, en_shift_bottom, dbg_state}, '0);
            repeat (3) @(negedge Clock);
            check("abort_no_done", done_cnt - done0, 0);
            check("abort_writes_done", wr_exp_q.size(), 0);
            out_exp_q.delete();
        end else if (do_rst) begin
            wait_state(3'd5, cyc);
            while (out_beats - beats0 < 2 && cyc < 1000) begin
                @(posedge Clock);
                #1;
                cyc++;
            end
            start = 1'b1;
            @(posedge Clock);
            #1;
            start = 1'b0;
            check("start_ignored_busy", dbg_state, 3'd5);
            @(negedge Clock);
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_mid_outs", all_outs(), '0);
            out_exp_q.delete();
            @(negedge Clock);
            rst_n = 1'b1;
            repeat (3) @(negedge Clock);
            check("rst_mid_idle", all_outs(), '0);
            check("rst_no_done", done_cnt - done0, 0);
        end else begin
            got = 1'b0;
            while (!got && cyc < 2000) begin
                @(negedge Clock);
                if (done) got = 1'b1;
                else begin
                    @(posedge Clock);
                    #1;
                    cyc++;
                end
            end
            check("done_seen", got, 1'b1);
            if (chk_lat) check(skip ? "latency_skip" : "latency_full", cyc, skip ? 34 : 98);
            check("writes_left", wr_exp_q.size(), 0);
            check("outs_left", out_exp_q.size(), 0);
            check("shift_cycles", shift_cnt - shift0, CC);
            check("clear_pulses", clear_cnt - clear0, 1);
            check("out_beat_count", out_beats - beats0, N);
            @(negedge Clock);
            check("busy_after_done", {busy, done}, 2'b00);
            check("done_pulses", done_cnt - done0, 1);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        skip_b = 1'b0;
        abort  = 1'b0;
        for (int c = 0; c < N; c++) col_sum[c] = '0;
        for (int i = 0; i < N * N; i++) b_mem[i] = '0;
        repeat (3) @(negedge Clock);
        check("reset_outs", all_outs(), '0);
        rst_n = 1'b1;
        repeat (2) @(negedge Clock);
        check("post_reset_outs", all_outs(), '0);

        run_pass(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_pass(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        valid_pct = 50;
        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        valid_pct = 100;
        stall_left = 5;
        run_pass(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_consumed", stall_left, 0);
        run_pass(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_pass(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            valid_pct = $urandom_range(100, 30);
            run_pass(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        valid_pct = 100;
        repeat (2) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
